blk_423401: RTL and testbench
=============================

# eth_std_main_system_peripheral_subsystem_led_driver

LED output stage placed directly downstream of the peripheral-subsystem LED PIO: it consumes the PIO's 8-bit `out_port` and drives the board LED pins. It adds global PWM dimming, per-LED blinking and polarity inversion, all configured through a small Avalon-MM slave in the same subsystem. After reset its defaults give a one-cycle registered pass-through of the PIO value, so existing software is unaffected.

## Interface
- `PRESCALE`, default 50: `clk` cycles per PWM/blink tick; legal range 1..65535.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset. One clock domain only; no asynchronous reset path.
- `address` input 2: Avalon-MM register select.
- `chipselect` input 1: Avalon-MM select.
- `write_n` input 1: Avalon-MM write strobe, active low.
- `writedata` input 32: Avalon-MM write data.
- `readdata` output 32: Avalon-MM read data. Combinational, zero wait states; unused bits read as 0.
- `led_in` input 8: LED pattern from the LED PIO `out_port`.
- `led_out` output 8: registered LED pin drive.

## Operation
- Registers. A write occurs when `chipselect && !write_n`.
  - addr 0, CTRL (R/W): bit0 `enable`, bit1 `invert`. Reset value 0x1.
  - addr 1, DUTY (R/W): bits 7:0 `duty`. Reset value 0xFF.
  - addr 2, BLINK (R/W): bits 7:0 `blink_mask`, bits 23:8 `half_period` in ticks. Reset value 0.
  - addr 3, STATUS (RO, writes ignored): bits 7:0 `pwm_cnt`, bit8 `blink_phase`, bit9 `tick`.
- Prescaler: counts 0..PRESCALE-1. `tick` is asserted for one `clk` cycle when the count equals PRESCALE-1, then the count wraps to 0. With PRESCALE=1, `tick` is high every cycle.
- PWM:
  - 8-bit `pwm_cnt` increments on each `tick` and wraps 255→0.
  - `pwm_on = (duty == 8'hFF) || (duty > pwm_cnt)`.
  - duty=0 gives always off; duty=0xFF gives always on; any other value N gives N/256 on-time.
- Blink:
  - 16-bit `blink_cnt` increments on `tick`.
  - When `blink_cnt == half_period-1` on a tick, `blink_cnt` returns to 0 and `blink_phase` toggles.
  - `half_period == 0`: counter and phase are held at 0.
  - Any write to BLINK clears `blink_cnt` and `blink_phase` in the same cycle the new value loads.
- Output, registered every cycle:
  - `masked = led_in & ~(blink_mask & {8{blink_phase}})`
  - `led_out <= enable ? ((masked & {8{pwm_on}}) ^ {8{invert}}) : {8{invert}}`
- Writes to DUTY or CTRL do not disturb `pwm_cnt`, the prescaler or the blink state.
- Reset values: `led_out` = 0x00, prescaler = 0, `pwm_cnt` = 0, `blink_cnt` = 0, `blink_phase` = 0, registers as listed above.
- Reset asserted mid-operation: every state element takes its reset value on the next `clk` edge, regardless of any simultaneous write.

## Timing
- `led_in` to `led_out`: 1 `clk` cycle latency.
- Register write at edge k: the new value is used to compute `led_out` at edge k+1 and is visible on `readdata` after edge k.
- A write coinciding with a `tick`:
  - DUTY/CTRL: the counters advance normally.
  - BLINK: the clear wins over the increment/toggle.
- Bus: `readdata` is valid in the same cycle as `address`; no `waitrequest`.
- PWM period = 256 × PRESCALE cycles. Blink full period = 2 × half_period × PRESCALE cycles.

## Configuration
- `ETH_STD_LED_DRIVER_BLINK_EN`
  - Defined: blink logic, BLINK register and STATUS bit8 exist as described.
  - Undefined: no blink counter or phase is built; BLINK reads 0 and writes to it are ignored; STATUS bit8 reads 0; `masked = led_in`.

## Test plan
- Reset, then drive `led_in`=0xA5 → `led_out`=0xA5 exactly one cycle later; CTRL reads 0x1, DUTY reads 0xFF.
- PRESCALE=1, DUTY=0x40, `led_in`=0xFF → over any 256-cycle window `led_out` is 0xFF for exactly 64 cycles; DUTY=0x00 → 0x00 constant.
- BLINK=0x0000_040F (half_period 4, mask 0x0F), PRESCALE=1, DUTY=0xFF, `led_in`=0xFF → `led_out` alternates 0xFF / 0xF0 every 4 cycles; a BLINK rewrite mid-phase restarts at phase 0.
- CTRL=0x2 (disabled, invert) → `led_out`=0xFF; CTRL=0x3 with `led_in`=0x0F, DUTY=0xFF → `led_out`=0xF0.
- Assert `reset` for one cycle during active blink/PWM, together with a DUTY write → all registers and `led_out` return to reset values and the write is discarded.
- Build without `ETH_STD_LED_DRIVER_BLINK_EN`: write BLINK=0x0000_04FF → readback 0, `led_out` follows `led_in` with no blinking.

Source files
------------

// File: rtl/blk_423401_if.sv
// Avalon-MM register bus between the LED driver and the subsystem interconnect.
interface blk_423401_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/blk_423401.sv
// LED output stage after the LED PIO: PWM dimming, per-LED blink and polarity invert.
// Blink logic is built only when ETH_STD_LED_DRIVER_BLINK_EN is defined.
module blk_423401 #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic        clk,
    input  logic        reset,
    blk_423401_if.slave bus,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        enable_q, enable_d;
    logic        invert_q, invert_d;
    logic [7:0]  duty_q, duty_d;
    logic [7:0]  led_q, led_d;

    logic        tick;
    logic        wr;
    logic        pwm_on;
    logic [7:0]  masked;
    logic [31:0] blink_rd;
    logic        phase_rd;

    assign wr = bus.chipselect && !bus.write_n;

`ifdef ETH_STD_LED_DRIVER_BLINK_EN
    logic [7:0]  blink_mask_q, blink_mask_d;
    logic [15:0] half_q, half_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        phase_q, phase_d;
    logic        unused_wdata;

    assign unused_wdata = ^bus.writedata[31:24];

    // A BLINK write restarts the pattern and takes priority over a coincident tick.
    always_comb begin
        blink_mask_d = blink_mask_q;
        half_d       = half_q;
        bcnt_d       = bcnt_q;
        phase_d      = phase_q;
        if (wr && bus.address == 2'd2) begin
            blink_mask_d = bus.writedata[7:0];
            half_d       = bus.writedata[23:8];
            bcnt_d       = '0;
            phase_d      = 1'b0;
        end else if (half_q == '0) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (bcnt_q == half_q - 16'd1) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask_q <= '0;
            half_q       <= '0;
            bcnt_q       <= '0;
            phase_q      <= 1'b0;
        end else begin
            blink_mask_q <= blink_mask_d;
            half_q       <= half_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
        end
    end

    assign masked   = led_in & ~(blink_mask_q & {8{phase_q}});
    assign blink_rd = {8'd0, half_q, blink_mask_q};
    assign phase_rd = phase_q;
`else
    logic unused_wdata;

    assign unused_wdata = ^bus.writedata[31:8];
    assign masked       = led_in;
    assign blink_rd     = '0;
    assign phase_rd     = 1'b0;
`endif

    assign tick   = (presc_q == PRE_MAX);
    assign pwm_on = (duty_q == 8'hFF) || (duty_q > pwm_cnt_q);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 16'd1;
        pwm_cnt_d = pwm_cnt_q + {7'd0, tick};
        enable_d  = enable_q;
        invert_d  = invert_q;
        duty_d    = duty_q;
        if (wr && bus.address == 2'd0) begin
            enable_d = bus.writedata[0];
            invert_d = bus.writedata[1];
        end
        if (wr && bus.address == 2'd1) begin
            duty_d = bus.writedata[7:0];
        end
        led_d = enable_q ? ((masked & {8{pwm_on}}) ^ {8{invert_q}}) : {8{invert_q}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            enable_q  <= 1'b1;
            invert_q  <= 1'b0;
            duty_q    <= 8'hFF;
            led_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            enable_q  <= enable_d;
            invert_q  <= invert_d;
            duty_q    <= duty_d;
            led_q     <= led_d;
        end
    end

    assign led_out = led_q;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = {30'd0, invert_q, enable_q};
            2'd1:    bus.readdata = {24'd0, duty_q};
            2'd2:    bus.readdata = blink_rd;
            default: bus.readdata = {22'd0, tick, phase_rd, pwm_cnt_q};
        endcase
    end

endmodule

// File: tb/tb_blk_423401.sv
// Scoreboard bench for the LED driver: stimulus queues expectations, a monitor checks them.
module tb_blk_423401;

    localparam int K_LED    = 0;
    localparam int K_RD     = 1;
    localparam int K_WSTART = 2;
    localparam int K_WEND   = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] led_in;
    logic [7:0] led_out;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ent_t sb[$];

    logic [7:0] win_val;
    bit         win_on = 1'b0;
    int         win_cnt = 0;

    blk_423401_if bus ();

    blk_423401 #(.PRESCALE(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .led_in (led_in),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int at, input logic [31:0] exp,
                        input logic [31:0] mask, input string name);
        ent_t e;
        e.kind = kind;
        e.cyc  = at;
        e.exp  = exp;
        e.mask = mask;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp_led(input logic [7:0] v, input string name);
        push(K_LED, cyc + 1, {24'd0, v}, 32'hFF, name);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic rd_exp(input logic [1:0] a, input logic [31:0] exp,
                          input logic [31:0] mask, input string name);
        bus.address = a;
        push(K_RD, cyc, exp, mask, name);
        step();
    endtask

    // Monitor: window starts first so the start sample itself is counted.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].kind == K_WSTART && sb[i].cyc == cyc) begin
                win_val = sb[i].exp[7:0];
                win_on  = 1'b1;
                win_cnt = 0;
                sb.delete(i);
            end else begin
                i++;
            end
        end
        if (win_on && led_out == win_val) win_cnt++;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                checks++;
                case (sb[i].kind)
                    K_LED: if (led_out !== sb[i].exp[7:0]) begin
                        failures++;
                        $display("FAIL %s: led_out=%h expected %h (cycle %0d)",
                                 sb[i].name, led_out, sb[i].exp[7:0], cyc);
                    end
                    K_RD: if ((bus.readdata & sb[i].mask) !== sb[i].exp) begin
                        failures++;
                        $display("FAIL %s: readdata=%h (mask %h) expected %h",
                                 sb[i].name, bus.readdata, sb[i].mask, sb[i].exp);
                    end
                    default: begin
                        win_on = 1'b0;
                        if (win_cnt != int'(sb[i].exp)) begin
                            failures++;
                            $display("FAIL %s: on-count=%0d expected %0d",
                                     sb[i].name, win_cnt, sb[i].exp);
                        end
                    end
                endcase
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: stimulus did not finish within cycle budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset          = 1'b1;
        led_in         = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        step();
        step();
        exp_led(8'h00, "reset_led");
        step();
        reset = 1'b0;
        step();

        // Pass-through with one-cycle latency and reset register values
        led_in = 8'hA5;
        push(K_LED, cyc, 32'h00, 32'hFF, "latency_before");
        exp_led(8'hA5, "latency_after");
        step();
        rd_exp(2'd0, 32'h1, 32'hFFFF_FFFF, "ctrl_reset");
        rd_exp(2'd1, 32'hFF, 32'hFFFF_FFFF, "duty_reset");
        rd_exp(2'd2, 32'h0, 32'hFFFF_FFFF, "blink_reset");
        rd_exp(2'd3, 32'h200, 32'hFFFF_FF00, "status_tick_phase");

        // PWM at 0x40: 64 of every 256 cycles on
        led_in = 8'hFF;
        wr(2'd1, 32'h40);
        step();
        push(K_WSTART, cyc + 1, 32'hFF, 32'hFF, "pwm_window");
        push(K_WEND, cyc + 256, 32'd64, 32'hFF, "pwm_duty40_count");
        repeat (256) step();
        rd_exp(2'd1, 32'h40, 32'hFFFF_FFFF, "duty_readback");

        wr(2'd1, 32'h00);
        step();
        for (int i = 0; i < 6; i++) begin
            exp_led(8'h00, "duty0_off");
            step();
        end

        // Polarity and enable
        wr(2'd0, 32'h2);
        exp_led(8'hFF, "disabled_invert");
        step();
        wr(2'd0, 32'h0);
        exp_led(8'h00, "disabled_noinvert");
        step();
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'h3);
        led_in = 8'h0F;
        exp_led(8'hF0, "enabled_invert");
        step();
        wr(2'd0, 32'h1);
        led_in = 8'hFF;
        step();

`ifdef ETH_STD_LED_DRIVER_BLINK_EN
        wr(2'd2, 32'h0000_040F);
        for (int i = 1; i <= 12; i++) begin
            exp_led((((i - 1) / 4) % 2 == 1) ? 8'hF0 : 8'hFF, "blink_pattern");
            step();
        end
        step();
        step();
        wr(2'd2, 32'h0000_040F);
        for (int i = 1; i <= 8; i++) begin
            exp_led((((i - 1) / 4) % 2 == 1) ? 8'hF0 : 8'hFF, "blink_restart");
            step();
        end
        rd_exp(2'd2, 32'h0000_040F, 32'hFFFF_FFFF, "blink_readback");
`else
        wr(2'd2, 32'h0000_04FF);
        rd_exp(2'd2, 32'h0, 32'hFFFF_FFFF, "blink_absent_readback");
        for (int i = 1; i <= 12; i++) begin
            led_in = 8'(i * 37);
            exp_led(8'(i * 37), "no_blink_follow");
            step();
        end
        rd_exp(2'd3, 32'h200, 32'hFFFF_FF00, "status_phase_zero");
        led_in = 8'hFF;
`endif

        // Reset mid-operation with a simultaneous DUTY write
        wr(2'd1, 32'h40);
        repeat (5) step();
        reset          = 1'b1;
        bus.address    = 2'd1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = 32'h10;
        exp_led(8'h00, "reset_midop_led");
        step();
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        led_in         = 8'h3C;
        exp_led(8'h3C, "after_reset_follow");
        step();
        rd_exp(2'd0, 32'h1, 32'hFFFF_FFFF, "ctrl_after_reset");
        rd_exp(2'd1, 32'hFF, 32'hFFFF_FFFF, "duty_after_reset");
        rd_exp(2'd2, 32'h0, 32'hFFFF_FFFF, "blink_after_reset");

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
